// File: rtl/clk_en_gen.sv
// Clock-enable generator: qualifies a raw PLL lock, releases per-channel resets
// in a staggered sequence, then produces divided one-cycle enable pulses per channel.
module clk_en_gen #(
  parameter int NCH         = 2,
  parameter int DIVW        = 8,
  parameter int LOCK_FILT   = 16,
  parameter int RST_STAGGER = 4
) (
  input  logic                CLK0,
  input  logic                RESETN,
  input  logic                PLL_LOCK,
  input  logic [NCH*DIVW-1:0] DIV,
  input  logic                LOST_CLR,
  output logic                LOCK_OK,
  output logic                LOCK_LOST,
  output logic [NCH-1:0]      RST_N_OUT,
  output logic [NCH-1:0]      CE
);

  localparam int FW = $clog2(LOCK_FILT);
  localparam int SW = $clog2(RST_STAGGER * NCH + 1);

  typedef enum logic [1:0] {UNLOCKED, FILTER, RELEASE, RUN} state_t;

  state_t          state;
  logic            lock_m;
  logic            lock_s;
  logic [FW-1:0]   filt_cnt;
  logic [SW-1:0]   stag_cnt;
  logic [DIVW-1:0] div_cnt [NCH];
  logic            lose;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK0 or negedge RESETN) begin
    if (!RESETN) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= PLL_LOCK;
      lock_s <= lock_m;
    end
  end

  assign lose = (state != UNLOCKED) && !lock_s;

  always_ff @(posedge CLK0 or negedge RESETN) begin
    if (!RESETN) begin
      state     <= UNLOCKED;
      filt_cnt  <= '0;
      stag_cnt  <= '0;
      LOCK_OK   <= 1'b0;
      LOCK_LOST <= 1'b0;
      RST_N_OUT <= '0;
    end else begin
      // Clear first, set later in the block: a coincident loss overrides the clear.
      if (LOST_CLR)
        LOCK_LOST <= 1'b0;
      if (lose && (state == RELEASE || state == RUN))
        LOCK_LOST <= 1'b1;

      if (lose) begin
        state     <= UNLOCKED;
        filt_cnt  <= '0;
        stag_cnt  <= '0;
        LOCK_OK   <= 1'b0;
        RST_N_OUT <= '0;
      end else begin
        case (state)
          UNLOCKED: begin
            if (lock_s) begin
              state    <= FILTER;
              filt_cnt <= '0;
            end
          end
          FILTER: begin
            // The UNLOCKED->FILTER cycle already counted as the first high sample.
            if (filt_cnt == FW'(LOCK_FILT - 2)) begin
              state    <= RELEASE;
              LOCK_OK  <= 1'b1;
              filt_cnt <= '0;
              stag_cnt <= '0;
            end else begin
              filt_cnt <= filt_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (RST_N_OUT[NCH-1]) begin
              state    <= RUN;
              stag_cnt <= '0;
            end else begin
              stag_cnt <= stag_cnt + 1'b1;
              for (int i = 0; i < NCH; i++)
                if (stag_cnt == SW'(RST_STAGGER * (i + 1) - 1))
                  RST_N_OUT[i] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the divider counters are a handful of flops, not a RAM, so they take
  // the asynchronous reset like any other state.
  always_ff @(posedge CLK0 or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NCH; i++)
        div_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!RST_N_OUT[i] || lose || CE[i])
          div_cnt[i] <= '0;
        else
          div_cnt[i] <= div_cnt[i] + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    CE = '0;
    for (int i = 0; i < NCH; i++)
      CE[i] = RST_N_OUT[i] && (div_cnt[i] >= DIV[i*DIVW +: DIVW]);
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen with default parameters:
// lock qualification, glitch filtering, dividers, loss/clear and resets.
module tb_clk_en_gen;

  localparam int NCH  = 2;
  localparam int DIVW = 8;

  logic                CLK0 = 1'b0;
  logic                RESETN;
  logic                PLL_LOCK;
  logic [NCH*DIVW-1:0] DIV;
  logic                LOST_CLR;
  logic                LOCK_OK;
  logic                LOCK_LOST;
  logic [NCH-1:0]      RST_N_OUT;
  logic [NCH-1:0]      CE;

  int checks = 0;
  int errors = 0;

  always #5 CLK0 = ~CLK0;

  clk_en_gen dut (
    .CLK0      (CLK0),
    .RESETN    (RESETN),
    .PLL_LOCK  (PLL_LOCK),
    .DIV       (DIV),
    .LOST_CLR  (LOST_CLR),
    .LOCK_OK   (LOCK_OK),
    .LOCK_LOST (LOCK_LOST),
    .RST_N_OUT (RST_N_OUT),
    .CE        (CE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK0);
    #1;
  endtask

  logic [1:0] exp_ce;

  initial begin
    RESETN   = 1'b0;
    PLL_LOCK = 1'b0;
    LOST_CLR = 1'b0;
    DIV      = {8'd3, 8'd0};
    #2;
    check("rst_lock_ok",   LOCK_OK,   0);
    check("rst_lock_lost", LOCK_LOST, 0);
    check("rst_rst_n_out", RST_N_OUT, 0);
    check("rst_ce",        CE,        0);

    step(2);
    RESETN = 1'b1;
    step(3);
    check("idle_lock_ok", LOCK_OK, 0);

    // Lock qualification: LOCK_OK 18 edges after PLL_LOCK rises
    PLL_LOCK = 1'b1;
    step(17);
    check("qual_e17_lock_ok", LOCK_OK, 0);
    step(1);
    check("qual_e18_lock_ok", LOCK_OK, 1);
    check("qual_e18_rst",     RST_N_OUT, 2'b00);
    step(3);
    check("qual_e21_rst", RST_N_OUT, 2'b00);
    step(1);
    check("qual_e22_rst", RST_N_OUT, 2'b01);
    check("qual_e22_ce",  CE,        2'b01);
    step(3);
    check("qual_e25_rst", RST_N_OUT, 2'b01);
    step(1);
    check("qual_e26_rst", RST_N_OUT, 2'b11);
    check("qual_e26_ce",  CE,        2'b01);

    // Dividers DIV0=0, DIV1=3: CE1 on the 3rd edge after release, then every 4
    for (int k = 1; k <= 8; k++) begin
      step(1);
      exp_ce[0] = 1'b1;
      exp_ce[1] = (k % 4 == 3);
      check("div_ce", CE, exp_ce);
    end

    // Loss in RUN: outputs drop on the 3rd edge
    PLL_LOCK = 1'b0;
    step(2);
    check("loss_e2_lock_ok", LOCK_OK,   1);
    check("loss_e2_rst",     RST_N_OUT, 2'b11);
    step(1);
    check("loss_e3_lock_ok",   LOCK_OK,   0);
    check("loss_e3_rst",       RST_N_OUT, 2'b00);
    check("loss_e3_ce",        CE,        2'b00);
    check("loss_e3_lock_lost", LOCK_LOST, 1);
    step(2);
    LOST_CLR = 1'b1;
    step(1);
    LOST_CLR = 1'b0;
    check("clr_lock_lost", LOCK_LOST, 0);

    // Relock, lose during RELEASE with LOST_CLR on the same edge
    PLL_LOCK = 1'b1;
    step(18);
    check("relock_lock_ok", LOCK_OK, 1);
    PLL_LOCK = 1'b0;
    step(2);
    LOST_CLR = 1'b1;
    step(1);
    LOST_CLR = 1'b0;
    check("coinc_lock_lost", LOCK_LOST, 1);
    check("coinc_lock_ok",   LOCK_OK,   0);
    step(1);
    LOST_CLR = 1'b1;
    step(1);
    LOST_CLR = 1'b0;
    check("clr2_lock_lost", LOCK_LOST, 0);

    // Glitch: 10 cycles high, 1 low, then high; lock_s re-rises at edge 13
    PLL_LOCK = 1'b1;
    step(10);
    PLL_LOCK = 1'b0;
    step(1);
    PLL_LOCK = 1'b1;
    step(7);
    check("glitch_g18_lock_ok", LOCK_OK, 0);
    step(10);
    check("glitch_g28_lock_ok", LOCK_OK, 0);
    step(1);
    check("glitch_g29_lock_ok",   LOCK_OK,   1);
    check("glitch_g29_lock_lost", LOCK_LOST, 0);
    step(4);
    check("glitch_g33_rst", RST_N_OUT, 2'b01);

    // Asynchronous reset mid-RELEASE
    #2;
    RESETN = 1'b0;
    #1;
    check("arst_lock_ok",   LOCK_OK,   0);
    check("arst_rst",       RST_N_OUT, 2'b00);
    check("arst_ce",        CE,        2'b00);
    check("arst_lock_lost", LOCK_LOST, 0);
    #2;
    RESETN = 1'b1;
    step(17);
    check("rerun_r17_lock_ok", LOCK_OK, 0);
    step(1);
    check("rerun_r18_lock_ok", LOCK_OK, 1);
    DIV = {8'd200, 8'd0};
    step(4);
    check("rerun_r22_rst", RST_N_OUT, 2'b01);
    step(4);
    check("rerun_r26_rst", RST_N_OUT, 2'b11);

    // DIV shrink 200 -> 5 while channel-1 counter is 50
    step(50);
    check("shrink_pre_ce", CE, 2'b01);
    DIV = {8'd5, 8'd0};
    #1;
    check("shrink_now_ce", CE, 2'b11);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_ce[0] = 1'b1;
      exp_ce[1] = (k % 6 == 0);
      check("shrink_ce", CE, exp_ce);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
